// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared types and helpers for the line-granular backing memory.
//   state_t    : controller states (IDLE, BUSY, DONE)
//   line_bits  : width in bits of one line for a given log2(words per line)
//   init_word  : power-up content of word k of line a
package line_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned WORD_W = 32;

  function automatic int unsigned line_bits(input int unsigned line_addr_len);
    return WORD_W << line_addr_len;
  endfunction

  // Word k of line a powers up as {a, k}, which makes every word of the memory unique.
  function automatic logic [31:0] init_word(input int unsigned a,
                                            input int unsigned k,
                                            input int unsigned line_addr_len);
    return (a << line_addr_len) | k;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// line_mem_array: single-port, line-wide storage.
//   clk     : clock, rising edge
//   i_we    : write enable, writes i_wdata to line i_addr at the clock edge
//   i_addr  : line address (shared by read and write)
//   i_wdata : write line
//   o_rdata : combinational read of line i_addr
// Contents are set at time 0 to the init_word pattern and have no reset.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter  int unsigned LINE_ADDR_LEN = 3,
  parameter  int unsigned ADDR_LEN      = 7,
  localparam int unsigned LB            = line_bits(LINE_ADDR_LEN)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDR_LEN-1:0] i_addr,
  input  logic [LB-1:0]       i_wdata,
  output logic [LB-1:0]       o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_LEN;
  localparam int unsigned WORDS = 1 << LINE_ADDR_LEN;

  typedef logic [DEPTH-1:0][WORDS-1:0][WORD_W-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        m[ADDR_LEN'(a)][LINE_ADDR_LEN'(k)] = init_word(a, k, LINE_ADDR_LEN);
      end
    end
    return m;
  endfunction

  mem_t r_mem = init_mem();

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/line_mem_model.sv
// line_mem_model: line-granular backing memory behind the set-associative cache.
// Serves whole-line reads (SWAP_IN) and write-backs (SWAP_OUT) over a level
// request / one-cycle gnt handshake, with a fixed LATENCY wait per access.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset (storage contents are kept)
//   addr    : line address, sampled when the request is accepted
//   rd_req  : line read request, held until gnt
//   wr_req  : line write request, held until gnt; wins over rd_req
//   wr_line : write data, word k in bits [32k+31:32k], sampled at acceptance
//   rd_line : registered read data, valid while gnt=1, held until the next read
//   gnt     : one-cycle completion pulse
// Optional build macro LINE_MEM_STATS_EN adds rd_cnt / wr_cnt: saturating
// 32-bit counts of completed reads and writes, cleared by rst.
module line_mem_model
  import line_mem_pkg::*;
#(
  parameter  int unsigned LINE_ADDR_LEN = 3,
  parameter  int unsigned ADDR_LEN      = 7,
  parameter  int unsigned LATENCY       = 4,
  localparam int unsigned LB            = line_bits(LINE_ADDR_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [LB-1:0]       wr_line,
  output logic [LB-1:0]       rd_line,
  output logic                gnt
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]         rd_cnt,
  output logic [31:0]         wr_cnt
`endif
);

  localparam int unsigned       CNT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_LEN-1:0] r_addr;
  logic                r_op_wr;
  logic [LB-1:0]       r_wdata;
  logic [LB-1:0]       r_rd_line;
  logic                r_gnt;

  logic                w_req;
  logic                w_we;
  logic [ADDR_LEN-1:0] w_mem_addr;
  logic [LB-1:0]       w_mem_rdata;

  assign w_req = rd_req | wr_req;
  // The write lands at the edge that ends DONE, so a reset during DONE drops it.
  assign w_we  = (r_state == DONE) && r_op_wr;
  // In IDLE the array looks at the live address so a zero-latency read can
  // load rd_line on the accepting edge; afterwards only the latched address counts.
  assign w_mem_addr = (r_state == IDLE) ? addr : r_addr;

  line_mem_array #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .ADDR_LEN     (ADDR_LEN)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (w_mem_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_op_wr   <= 1'b0;
      r_wdata   <= '0;
      r_rd_line <= '0;
      r_gnt     <= 1'b0;
    end else begin
      r_gnt <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= addr;
            r_op_wr <= wr_req;
            r_wdata <= wr_line;
            r_cnt   <= LAT_INIT;
            if (LATENCY == 0) begin
              r_state <= DONE;
              r_gnt   <= 1'b1;
              if (!wr_req) begin
                r_rd_line <= w_mem_rdata;
              end
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= DONE;
            r_gnt   <= 1'b1;
            if (!r_op_wr) begin
              r_rd_line <= w_mem_rdata;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rd_line = r_rd_line;
  assign gnt     = r_gnt;

`ifdef LINE_MEM_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (r_state == DONE) begin
      if (r_op_wr) begin
        if (r_wr_cnt != '1) begin
          r_wr_cnt <= r_wr_cnt + 32'd1;
        end
      end else begin
        if (r_rd_cnt != '1) begin
          r_rd_cnt <= r_rd_cnt + 32'd1;
        end
      end
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`endif

endmodule
